// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants for the RGB PWM driver: channel width, frame length and
// the {R,G,B} slice positions inside the 24-bit colour word.
package rgb_pwm_driver_pkg;

  localparam int CH_W        = 8;
  localparam int FRAME_TICKS = 255;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  localparam logic [CH_W-1:0] CNT_LAST = CH_W'(FRAME_TICKS - 1);

  // The tick counter wraps explicitly so it never reaches 255; a duty of 255
  // therefore compares true on every tick of the frame.
  function automatic logic [CH_W-1:0] next_cnt(input logic [CH_W-1:0] cnt);
    return (cnt == CNT_LAST) ? '0 : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM output: registered unsigned compare of the frame tick counter
// against the latched duty, forced low while disabled.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [CH_W-1:0] cnt,
  input  logic [CH_W-1:0] duty,
  output logic            pwm
);

  logic pwm_d;
  logic pwm_q;

  always_comb begin
    pwm_d = enable && (cnt < duty);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with frame-synchronous colour double buffering
// and a one-cycle frame_start marker.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start
);

  if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
    $error("rgb_pwm_driver: PRESCALE must be in 1..255");
  end

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0]      pre_q,    pre_d;
  logic [CH_W-1:0] cnt_q,    cnt_d;
  logic [23:0]     shadow_q, shadow_d;
  logic            frame_start_q, frame_start_d;
  logic            tick;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tick          = (pre_q == PRE_LAST);
    pre_d         = '0;
    cnt_d         = '0;
    shadow_d      = rgb;
    frame_start_d = 1'b0;
    if (enable) begin
      pre_d         = tick ? '0 : pre_q + 8'd1;
      cnt_d         = cnt_q;
      shadow_d      = shadow_q;
      frame_start_d = (pre_q == '0) && (cnt_q == '0);
      if (tick) begin
        cnt_d = next_cnt(cnt_q);
        // Frame boundary: the only point a running driver accepts a new colour.
        if (cnt_q == CNT_LAST) begin
          shadow_d = rgb;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
    end
  end

  pwm_channel u_ch_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (cnt_q),
    .duty   (shadow_q[R_HI:R_LO]),
    .pwm    (pwm_r)
  );

  pwm_channel u_ch_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (cnt_q),
    .duty   (shadow_q[G_HI:G_LO]),
    .pwm    (pwm_g)
  );

  pwm_channel u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (cnt_q),
    .duty   (shadow_q[B_HI:B_LO]),
    .pwm    (pwm_b)
  );

  assign frame_start = frame_start_q;

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage of the RGB colour converter. Consumes the 24-bit rgb word (R in [23:16], G in [15:8], B in [7:0]) and drives three PWM LED outputs whose duty cycle is proportional to each 8-bit channel. The block double-buffers the colour so that a change only takes effect at a frame boundary, which keeps the outputs glitch-free. A frame_start pulse marks each frame for debug and scope triggering.

Parameters:
- PRESCALE, 4, clk cycles per PWM tick; legal range 1..255.
- CH_W, 8, bits per colour channel; fixed at 8, so the frame is 255 ticks.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- enable  input  1  run PWM when high; when low, outputs are forced off
- rgb  input  24  colour word from the converter {R,G,B}
- pwm_r  output  1  red LED drive, active-high
- pwm_g  output  1  green LED drive, active-high
- pwm_b  output  1  blue LED drive, active-high
- frame_start  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Internal registers: pre (prescaler, 0..PRESCALE-1), cnt (tick counter, 0..254), shadow[23:0] (latched duties).
- Reset (rst_n=0 at a clk edge): pre, cnt, shadow, pwm_r/g/b and frame_start all go to 0. Reset has priority over enable. Reset mid-frame aborts the frame with no partial pulse afterwards.
- enable=0 (rst_n=1):
  - pre and cnt are held at 0.
  - shadow <= rgb on every cycle, so the first frame after enable uses the current colour.
  - pwm_r/g/b <= 0 and frame_start <= 0.
- enable=1, per clk edge:
  - tick = (pre == PRESCALE-1).
  - pre <= tick ? 0 : pre+1.
  - On tick: cnt <= (cnt == 254) ? 0 : cnt+1.
  - On tick with cnt == 254: shadow <= rgb. This is the frame boundary and the only point where colour updates are accepted while running.
  - pwm_x <= (cnt < shadow_x), a registered unsigned 8-bit compare against the current cnt.
  - frame_start <= (pre == 0 && cnt == 0).
- Latency: outputs lag the counter state by one cycle. The first frame_start and the first pwm high appear 1 cycle after the first enable=1 edge.
- Frame length is 255*PRESCALE cycles. High time per frame for channel duty d is exactly d*PRESCALE cycles.
  - d=0: output never high.
  - d=255: output high for the whole frame, so continuously high across frames.
- rgb changes mid-frame have no effect until the next frame boundary.
- Dropping enable mid-frame: on the next edge all outputs are 0 and the counters are cleared. Re-enabling starts a fresh frame.
- PRESCALE=1: tick is asserted every cycle and pre stays at 0.
- No arithmetic overflow: cnt wraps at 254→0 explicitly and never reaches 255.

Decomposition:
- Shared package holds:
  - localparam CH_W=8.
  - localparam FRAME_TICKS=255.
  - Channel slice indices: R_HI=23, R_LO=16, G_HI=15, G_LO=8, B_HI=7, B_LO=0.
- One natural sub-module, pwm_channel: takes clk, rst_n, enable, cnt[7:0] and duty[7:0], and produces a registered pwm output. It is instantiated three times.
- The prescaler, cnt and shadow logic stay in the top level.

Test Plan:
- PRESCALE=2, rst_n=0 for 3 cycles with enable=1 and rgb=24'hFFFFFF → all outputs 0 throughout reset. After release, first frame_start appears 1 cycle later.
- PRESCALE=2, rgb=24'hFF8000, enable=1 → per 510-cycle frame: pwm_r high 510 cycles, pwm_g high 256 cycles starting at frame_start, pwm_b 0. frame_start period is 510.
- PRESCALE=1, rgb=24'h01FE00 → pwm_r high 1 cycle per 255-cycle frame, pwm_g high 254 cycles, pwm_b 0.
- PRESCALE=2, rgb changes from 24'h000000 to 24'h0000FF at cycle 100 of a frame → pwm_b stays 0 for the rest of that frame. It is high for 510 cycles from the next frame_start.
- Drop enable at cycle 300 of a frame, re-raise it 20 cycles later with rgb=24'h400000 → outputs 0 on the edge after enable=0. A new frame_start follows 1 cycle after re-enable. pwm_r is then high 128 cycles.
- Assert rst_n=0 for 1 cycle mid-frame while pwm_g is high → pwm_g=0 on the next edge. Counters restart from 0 and shadow=0, so all outputs stay 0 until the next frame boundary loads rgb.
